// File: rtl/word_to_symbols.sv
// rtl/word_to_symbols.sv - serialise one wide stream word into SYM_BITS-wide symbols
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   word_valid/ready input word handshake (word_ready is combinational from sym_ready)
//   word_data        input word, sampled only on accept
//   word_count       symbols to emit (1..N; 0 and values above N mean N)
//   word_last        word ends a packet
//   sym_valid/ready  output symbol handshake
//   sym_data         current symbol (registered)
//   sym_last         high on the final symbol of a word_last word
module word_to_symbols #(
    parameter int WORD_BITS = 32,
    parameter int SYM_BITS  = 8,
    parameter int MSB_FIRST = 0,
    parameter int CW        = $clog2(WORD_BITS / SYM_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic [WORD_BITS-1:0] word_data,
    input  logic [CW-1:0]        word_count,
    input  logic                 word_last,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [SYM_BITS-1:0]  sym_data,
    output logic                 sym_last
);

    localparam int N = WORD_BITS / SYM_BITS;

    generate
        if ((WORD_BITS % SYM_BITS) != 0 || N < 2) begin : g_bad_params
            $error("word_to_symbols: WORD_BITS must be a multiple of SYM_BITS with at least 2 symbols");
        end
    endgenerate

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_LOADED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WORD_BITS-1:0] r_shift;
    logic [CW-1:0]        r_rem;
    logic                 r_last;

    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_final;
    logic [CW-1:0]        w_eff_count;
    logic [WORD_BITS-1:0] w_shift_next;

    // r_rem is zero whenever the block is EMPTY, so w_final alone marks the
    // last symbol of a loaded word.
    assign w_final  = (r_rem == CW'(1));
    assign w_xfer   = (r_state == S_LOADED) && sym_ready;

    assign word_ready = !rst && ((r_state == S_EMPTY) || (sym_ready && w_final));
    assign w_accept   = word_valid && word_ready;

    assign w_eff_count = ((word_count == '0) || (word_count > CW'(N))) ? CW'(N) : word_count;

    // Symbol 0 sits at the end of the register that sym_data reads from, so the
    // register moves toward that end by one symbol per transfer.
    assign w_shift_next = (MSB_FIRST != 0) ? (r_shift << SYM_BITS) : (r_shift >> SYM_BITS);

    assign sym_valid = (r_state == S_LOADED);
    assign sym_data  = (MSB_FIRST != 0) ? r_shift[WORD_BITS-1 -: SYM_BITS] : r_shift[SYM_BITS-1:0];
    assign sym_last  = r_last && w_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next_state = S_LOADED;
                end
            end
            S_LOADED: begin
                if (sym_ready && w_final && !w_accept) begin
                    w_next_state = S_EMPTY;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_rem   <= '0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_shift <= word_data;
            r_rem   <= w_eff_count;
            r_last  <= word_last;
        end else if (w_xfer) begin
            // On the final symbol the register is left alone so sym_data
            // keeps showing the last symbol while EMPTY.
            if (!w_final) begin
                r_shift <= w_shift_next;
            end
            r_rem <= r_rem - CW'(1);
        end
    end

endmodule

// File: tb/tb_word_to_symbols.sv
// tb/tb_word_to_symbols.sv - scoreboard bench for word_to_symbols in four configurations
module tb_word_to_symbols;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        last;
    } sym_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wv [4];
    logic        wr [4];
    logic        wl [4];
    logic [2:0]  wc [4];
    logic        sv [4];
    logic        sr [4];
    logic        sl [4];
    logic [31:0] wd32 [2];
    logic [63:0] wd64 [2];
    logic [7:0]  sd8 [2];
    logic [15:0] sd16 [2];

    sym_t expq [4][$];
    sym_t obs  [4][$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_to_symbols #(.WORD_BITS(32), .SYM_BITS(8), .MSB_FIRST(0)) u_lsb32 (
        .clk(clk), .rst(rst), .word_valid(wv[0]), .word_ready(wr[0]), .word_data(wd32[0]),
        .word_count(wc[0]), .word_last(wl[0]), .sym_valid(sv[0]), .sym_ready(sr[0]),
        .sym_data(sd8[0]), .sym_last(sl[0]));
    word_to_symbols #(.WORD_BITS(32), .SYM_BITS(8), .MSB_FIRST(1)) u_msb32 (
        .clk(clk), .rst(rst), .word_valid(wv[1]), .word_ready(wr[1]), .word_data(wd32[1]),
        .word_count(wc[1]), .word_last(wl[1]), .sym_valid(sv[1]), .sym_ready(sr[1]),
        .sym_data(sd8[1]), .sym_last(sl[1]));
    word_to_symbols #(.WORD_BITS(64), .SYM_BITS(16), .MSB_FIRST(0)) u_lsb64 (
        .clk(clk), .rst(rst), .word_valid(wv[2]), .word_ready(wr[2]), .word_data(wd64[0]),
        .word_count(wc[2]), .word_last(wl[2]), .sym_valid(sv[2]), .sym_ready(sr[2]),
        .sym_data(sd16[0]), .sym_last(sl[2]));
    word_to_symbols #(.WORD_BITS(64), .SYM_BITS(16), .MSB_FIRST(1)) u_msb64 (
        .clk(clk), .rst(rst), .word_valid(wv[3]), .word_ready(wr[3]), .word_data(wd64[1]),
        .word_count(wc[3]), .word_last(wl[3]), .sym_valid(sv[3]), .sym_ready(sr[3]),
        .sym_data(sd16[1]), .sym_last(sl[3]));

    // Record every symbol transfer, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sv[i] && sr[i]) begin
                sym_t o;
                o.cyc  = cyc;
                o.data = (i < 2) ? {8'h00, sd8[i % 2]} : sd16[i % 2];
                o.last = sl[i];
                obs[i].push_back(o);
            end
        end
    end

    function automatic logic [15:0] model_sym(int i, logic [63:0] w, int j);
        int s  = (i < 2) ? 8 : 16;
        int wb = (i < 2) ? 32 : 64;
        int sh = (i % 2 == 1) ? (wb - (j + 1) * s) : (j * s);
        logic [63:0] t = w >> sh;
        return (s == 8) ? {8'h00, t[7:0]} : t[15:0];
    endfunction

    task automatic push_word(input int i, input logic [63:0] w, input logic [2:0] c,
                             input logic l, input int acc, input bit timed);
        int k = (c == 3'd0 || c > 3'd4) ? 4 : int'(c);
        for (int j = 0; j < k; j++) begin
            sym_t e;
            e.cyc  = timed ? (acc + 1 + j) : -1;
            e.data = model_sym(i, w, j);
            e.last = l && (j == k - 1);
            expq[i].push_back(e);
        end
    endtask

    // mode 0: no scoreboard push, 1: push untimed, 2: push with expected cycles
    task automatic send_word(input int i, input logic [63:0] w, input logic [2:0] c,
                             input logic l, input int mode, output int acc);
        int t = 0;
        if (i < 2) wd32[i] = w[31:0]; else wd64[i - 2] = w;
        wc[i] = c;
        wl[i] = l;
        wv[i] = 1'b1;
        forever begin
            @(negedge clk);
            if (wr[i]) break;
            t++;
            if (t >= 50) break;
        end
        acc = cyc;
        n_tests++;
        if (!wr[i]) begin
            n_fail++;
            $display("FAIL accept timeout inst %0d: word_ready=%b, want 1", i, wr[i]);
        end else if (mode != 0) begin
            push_word(i, w, c, l, acc, mode == 2);
        end
        @(posedge clk); #1;
        wv[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic take(input int i, output sym_t e, output sym_t o, output bit got);
        e = expq[i].pop_front();
        got = (obs[i].size() > 0);
        if (got) o = obs[i].pop_front();
        else begin o.cyc = -1; o.data = '0; o.last = 1'b0; end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            wv[i] = 1'b1; sr[i] = 1'b1; wl[i] = 1'b1; wc[i] = 3'd4;
        end
        wd32[0] = 32'hFFFFFFFF; wd32[1] = 32'hFFFFFFFF; wd64[0] = '1; wd64[1] = '1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d = (i < 2) ? {8'h00, sd8[i % 2]} : sd16[i % 2];
            n_tests++;
            if (sv[i] !== 1'b0 || wr[i] !== 1'b0 || sl[i] !== 1'b0 || d !== 16'h0) begin
                n_fail++;
                $display("FAIL reset state inst %0d: got v=%b r=%b l=%b d=%h, want 0 0 0 0000",
                         i, sv[i], wr[i], sl[i], d);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) wv[i] = 1'b0;
        rst = 1'b0;
        idle(2);
        n_tests++;
        if (obs[0].size() + obs[1].size() + obs[2].size() + obs[3].size() != 0) begin
            n_fail++;
            $display("FAIL reset idle: got %0d symbols, want 0",
                     obs[0].size() + obs[1].size() + obs[2].size() + obs[3].size());
        end
    endtask

    task automatic test_basic;
        int a;
        sym_t e, o;
        bit got;
        sr[0] = 1'b1;
        send_word(0, 64'h44332211, 3'd0, 1'b0, 2, a);
        idle(6);
        while (expq[0].size() > 0) begin
            take(0, e, o, got);
            n_tests++;
            if (!got || o.data !== e.data || o.last !== e.last || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL basic symbol: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d",
                         o.data, o.last, o.cyc, e.data, e.last, e.cyc);
            end
        end
        n_tests++;
        if (obs[0].size() != 0) begin
            n_fail++;
            $display("FAIL basic extra: got %0d extra symbols, want 0", obs[0].size());
            obs[0].delete();
        end
    endtask

    task automatic test_back_to_back;
        int a1, a2;
        sym_t e, o;
        bit got;
        sr[1] = 1'b1;
        send_word(1, 64'hA1B2C3D4, 3'd4, 1'b0, 2, a1);
        send_word(1, 64'h01020304, 3'd4, 1'b0, 2, a2);
        idle(6);
        n_tests++;
        if (a2 != a1 + 4) begin
            n_fail++;
            $display("FAIL b2b accept cycle: got %0d, want %0d", a2, a1 + 4);
        end
        while (expq[1].size() > 0) begin
            take(1, e, o, got);
            n_tests++;
            if (!got || o.data !== e.data || o.last !== e.last || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL b2b symbol: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d",
                         o.data, o.last, o.cyc, e.data, e.last, e.cyc);
            end
        end
        n_tests++;
        if (obs[1].size() != 0) begin
            n_fail++;
            $display("FAIL b2b extra: got %0d extra symbols, want 0", obs[1].size());
            obs[1].delete();
        end
    endtask

    task automatic test_partial_last;
        int a;
        sym_t e, o;
        bit got;
        sr[0] = 1'b1;
        send_word(0, 64'hDDCCBBAA, 3'd2, 1'b1, 2, a);
        send_word(0, 64'h000000EE, 3'd1, 1'b1, 2, a);
        send_word(0, 64'h04030201, 3'd7, 1'b0, 2, a);
        idle(6);
        while (expq[0].size() > 0) begin
            take(0, e, o, got);
            n_tests++;
            if (!got || o.data !== e.data || o.last !== e.last || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL partial symbol: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d",
                         o.data, o.last, o.cyc, e.data, e.last, e.cyc);
            end
        end
        n_tests++;
        if (obs[0].size() != 0) begin
            n_fail++;
            $display("FAIL partial extra: got %0d extra symbols, want 0", obs[0].size());
            obs[0].delete();
        end
    endtask

    task automatic test_backpressure;
        int xf = 0;
        bit prev_stall = 0;
        logic [7:0] prev_d = '0;
        sym_t e, o;
        bit got;
        sr[0] = 1'b0;
        wd32[0] = 32'h44332211; wc[0] = 3'd4; wl[0] = 1'b0; wv[0] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (wr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp accept: got word_ready=%b, want 1", wr[0]);
        end
        push_word(0, 64'h44332211, 3'd4, 1'b0, cyc, 1'b0);
        @(posedge clk); #1;
        wv[0] = 1'b1;
        wd32[0] = 32'h99999999;
        for (int k = 0; k < 14; k++) begin
            sr[0] = (k % 3 == 0);
            @(negedge clk);
            if (sv[0]) begin
                n_tests++;
                if (wr[0] !== (sr[0] && xf == 3)) begin
                    n_fail++;
                    $display("FAIL bp word_ready k=%0d: got %b, want %b", k, wr[0], sr[0] && xf == 3);
                end
                if (prev_stall) begin
                    n_tests++;
                    if (sd8[0] !== prev_d) begin
                        n_fail++;
                        $display("FAIL bp stall hold k=%0d: got %h, want %h", k, sd8[0], prev_d);
                    end
                end
            end
            prev_stall = sv[0] && !sr[0];
            prev_d = sd8[0];
            if (sv[0] && sr[0]) xf++;
            if (xf == 4) wv[0] = 1'b0;
            @(posedge clk); #1;
        end
        wv[0] = 1'b0;
        sr[0] = 1'b1;
        idle(3);
        while (expq[0].size() > 0) begin
            take(0, e, o, got);
            n_tests++;
            if (!got || o.data !== e.data || o.last !== e.last) begin
                n_fail++;
                $display("FAIL bp symbol: got %h last=%b, want %h last=%b", o.data, o.last, e.data, e.last);
            end
        end
        n_tests++;
        if (obs[0].size() != 0) begin
            n_fail++;
            $display("FAIL bp extra: got %0d extra symbols, want 0", obs[0].size());
            obs[0].delete();
        end
    endtask

    task automatic test_reset_mid_word;
        int a;
        sym_t e, o;
        bit got;
        sr[0] = 1'b0;
        send_word(0, 64'h44332211, 3'd4, 1'b0, 0, a);
        e.cyc = -1; e.data = 16'h0011; e.last = 1'b0;
        expq[0].push_back(e);
        sr[0] = 1'b1;
        @(posedge clk); #1;
        sr[0] = 1'b1;
        rst = 1'b1;
        wv[0] = 1'b1; wd32[0] = 32'hCAFEBABE; wc[0] = 3'd4;
        @(negedge clk);
        n_tests++;
        if (sv[0] !== 1'b0 || wr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid reset: got sym_valid=%b word_ready=%b, want 0 0", sv[0], wr[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wv[0] = 1'b0;
        idle(4);
        send_word(0, 64'h88776655, 3'd4, 1'b0, 2, a);
        idle(6);
        while (expq[0].size() > 0) begin
            take(0, e, o, got);
            n_tests++;
            if (!got || o.data !== e.data || o.last !== e.last || (e.cyc >= 0 && o.cyc != e.cyc)) begin
                n_fail++;
                $display("FAIL mid reset symbol: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d",
                         o.data, o.last, o.cyc, e.data, e.last, e.cyc);
            end
        end
        n_tests++;
        if (obs[0].size() != 0) begin
            n_fail++;
            $display("FAIL mid reset extra: got %0d extra symbols, want 0", obs[0].size());
            obs[0].delete();
        end
    endtask

    task automatic test_random;
        int  exp_lasts [2] = '{0, 0};
        int  obs_lasts [2] = '{0, 0};
        bit  acc_now [2];
        sym_t e, o;
        bit got;
        for (int i = 2; i < 4; i++) begin
            wv[i] = 1'b0; sr[i] = 1'b0;
        end
        repeat (10000) begin
            @(negedge clk);
            for (int i = 2; i < 4; i++) begin
                acc_now[i - 2] = wv[i] && wr[i];
                if (acc_now[i - 2]) begin
                    push_word(i, wd64[i - 2], wc[i], wl[i], 0, 1'b0);
                    if (wl[i]) exp_lasts[i - 2]++;
                end
            end
            @(posedge clk); #1;
            for (int i = 2; i < 4; i++) begin
                if (!wv[i] || acc_now[i - 2]) begin
                    wv[i]      = ($urandom % 4) != 0;
                    wd64[i - 2] = {$urandom, $urandom};
                    wc[i]      = 3'($urandom_range(0, 7));
                    wl[i]      = ($urandom % 3) == 0;
                end
                sr[i] = ($urandom % 2) == 0;
            end
        end
        for (int i = 2; i < 4; i++) begin
            wv[i] = 1'b0; sr[i] = 1'b1;
        end
        idle(12);
        for (int i = 2; i < 4; i++) begin
            while (expq[i].size() > 0) begin
                take(i, e, o, got);
                if (got && o.last) obs_lasts[i - 2]++;
                n_tests++;
                if (!got || o.data !== e.data || o.last !== e.last) begin
                    n_fail++;
                    $display("FAIL random inst %0d symbol: got %h last=%b, want %h last=%b",
                             i, o.data, o.last, e.data, e.last);
                end
            end
            n_tests++;
            if (obs[i].size() != 0) begin
                n_fail++;
                $display("FAIL random inst %0d extra: got %0d extra symbols, want 0", i, obs[i].size());
                obs[i].delete();
            end
            n_tests++;
            if (obs_lasts[i - 2] != exp_lasts[i - 2] || exp_lasts[i - 2] == 0) begin
                n_fail++;
                $display("FAIL random inst %0d last count: got %0d, want %0d (nonzero)",
                         i, obs_lasts[i - 2], exp_lasts[i - 2]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            wv[i] = 1'b0; sr[i] = 1'b0; wl[i] = 1'b0; wc[i] = 3'd0;
        end
        wd32[0] = '0; wd32[1] = '0; wd64[0] = '0; wd64[1] = '0;
        #1;
        test_reset;
        test_basic;
        test_back_to_back;
        test_partial_last;
        test_backpressure;
        test_reset_mid_word;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/word_to_symbols.md
Name: word_to_symbols

Overview:
Parametrised successor to word_to_bytes. Serialises one WORD_BITS-wide stream word into N = WORD_BITS/SYM_BITS symbols on a valid/ready stream. Adds selectable symbol order, partial words via a per-word symbol count, and end-of-packet propagation. Sits between wide producers (random_source, DMA/packet engines) and narrow consumers (UART/byte sinks), with zero-bubble throughput of one symbol per clock.

Parameters:
WORD_BITS, 32, input word width; must be an integer multiple of SYM_BITS, with N >= 2
SYM_BITS, 8, output symbol width
MSB_FIRST, 0, 0: symbol 0 = word_data[SYM_BITS-1:0]; 1: symbol 0 = word_data[WORD_BITS-1 -: SYM_BITS]
CW, $clog2(N+1), width of word_count (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
word_valid  in  1  input word present
word_ready  out  1  input word accepted when word_valid && word_ready
word_data  in  WORD_BITS  input word
word_count  in  CW  number of symbols to emit, 1..N; 0 is treated as N; values > N are clamped to N
word_last  in  1  word ends a packet
sym_valid  out  1  output symbol present
sym_ready  in  1  sink accepts when sym_valid && sym_ready
sym_data  out  SYM_BITS  output symbol
sym_last  out  1  high only on the final symbol of a word_last word

Behaviour:
- Reset (asynchronous assert, synchronous release on clk):
  - sym_valid=0, sym_data=0, sym_last=0.
  - Holding register, remaining counter and last flag cleared.
  - word_ready=0 while rst is high.
- Two states:
  - EMPTY (sym_valid=0).
  - LOADED (sym_valid=1, remaining = symbols still to emit including the current one, 1..N).
- word_ready = !rst && (EMPTY || (sym_ready && remaining==1)). This is combinational from sym_ready. There is no other comb path input->output.
- Accept (word_valid && word_ready):
  - Next cycle sym_valid=1 and sym_data = symbol 0 of word_data per MSB_FIRST.
  - remaining = effective count (0 or >N maps to N).
  - The word is stored in a shift register; the last flag is latched.
- Symbol transfer with remaining>1: the shift register advances by SYM_BITS (right shift if MSB_FIRST=0, left if 1), sym_data takes the next symbol, and remaining decrements.
- Symbol transfer with remaining==1:
  - If a word is accepted the same cycle: go straight to the new word's symbol 0 (no bubble).
  - Otherwise: go to EMPTY, sym_valid=0, sym_data holds its value.
- Partial word (count k<N): emit symbols 0..k-1 only, in the configured order. Unsent symbols are discarded.
- sym_last = latched word_last && remaining==1. It is never asserted on a non-final symbol. With count=1 and last=1, the single symbol carries sym_last.
- Stall (sym_valid && !sym_ready): sym_data, sym_last and remaining are held stable. word_ready=0 in LOADED unless the conditions above hold.
- Latency: 1 clock from word accept to first sym_valid.
- Throughput: one symbol per clock with continuous sym_ready and word_valid.
- Reset mid-word: remaining symbols are dropped, the block returns to EMPTY, and no symbol is emitted after rst falls until a new accept.
- word_data, word_count and word_last are sampled only on accept. Changes while word_ready=0 are ignored.
- Elaboration check: WORD_BITS % SYM_BITS != 0, or N<2, halts elaboration.

Test Plan:
- Defaults, MSB_FIRST=0, sym_ready=1, one word 0x44332211 with count=0 and last=0 -> symbols 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 clock after accept; sym_last=0 throughout.
- MSB_FIRST=1, back-to-back words 0xA1B2C3D4 then 0x01020304, both count=4, sym_ready=1 -> 8 consecutive symbols A1,B2,C3,D4,01,02,03,04 with no bubble; the second word is accepted in the cycle D4 transfers.
- Partial/last: word 0xDDCCBBAA, count=2, last=1 -> exactly AA,BB; sym_last=1 on BB only. Then count=1, last=1 word 0x000000EE -> single EE with sym_last=1. A count=7 word is clamped and emits 4 symbols.
- Backpressure: sym_ready toggled 1,0,0,1,... during word 0x44332211 -> sym_data stable across stalls, word_ready=0 until the final symbol transfers, byte order intact.
- Reset mid-word: assert rst after symbol 0x11 of 0x44332211 -> sym_valid=0 and word_ready=0 during reset; after release the next word 0x88776655 yields 55,66,77,88 with no residue.
- Randomised: random_source (SPEED 3) into the DUT into random_sink (SPEED 1) for 100000 time units, with WORD_BITS=64, SYM_BITS=16 and both MSB_FIRST values -> scoreboard matches all symbols in order; sym_last count equals the count of last words.
